draw_wrarb: RTL and testbench

Two-requester AXI4 write-channel arbiter inside the draw block. It shares the single AXI4 master write path (AW/W/B) between two internal write sources, for example the drawing engine's pixel write-back and a frame-clear/fill engine. It grants one burst at a time in round-robin order and sequences the address, data and response phases. It also reports completion and write response status back to the granted requester.

---
 rtl/draw_wrarb_if.sv | 44 ++++
 rtl/draw_wrarb.sv | 127 ++++++++++++
 tb/tb_draw_wrarb.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/draw_wrarb_if.sv
// Requester-side and AXI4 write-master bundles for the draw block write arbiter.
// Packed requester buses are {requester1, requester0}.
interface draw_wrarb_req_if;
  logic [1:0]  REQ;
  logic [63:0] ADDR;
  logic [15:0] LEN;
  logic [63:0] WDATA;
  logic [7:0]  WSTRB;
  logic [1:0]  WVALID;
  logic [1:0]  WREADY;
  logic [1:0]  GNT;
  logic [1:0]  DONE;
  logic [1:0]  RESP;
  logic        BUSY;

  modport slave  (input  REQ, ADDR, LEN, WDATA, WSTRB, WVALID,
                  output WREADY, GNT, DONE, RESP, BUSY);
  modport master (output REQ, ADDR, LEN, WDATA, WSTRB, WVALID,
                  input  WREADY, GNT, DONE, RESP, BUSY);
endinterface

interface draw_wrarb_axi_if;
  logic [31:0] M_AXI_AWADDR;
  logic [7:0]  M_AXI_AWLEN;
  logic        M_AXI_AWVALID;
  logic        M_AXI_AWREADY;
  logic [31:0] M_AXI_WDATA;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_WLAST;
  logic        M_AXI_WVALID;
  logic        M_AXI_WREADY;
  logic [1:0]  M_AXI_BRESP;
  logic        M_AXI_BVALID;
  logic        M_AXI_BREADY;

  modport master (output M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWVALID,
                         M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID,
                         M_AXI_BREADY,
                  input  M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID);
  modport slave  (input  M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWVALID,
                         M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID,
                         M_AXI_BREADY,
                  output M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID);
endinterface

// File: rtl/draw_wrarb.sv
// Round-robin arbiter sharing one AXI4 write master between two internal write
// sources; one burst in flight, sequenced through address, data and response.
module draw_wrarb (
  input logic              CLK,
  input logic              ARST,
  draw_wrarb_req_if.slave  req_if,
  draw_wrarb_axi_if.master axi_if
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [1:0]  gnt_q, gnt_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        last_q, last_d;
  logic [1:0]  resp_q, resp_d;

  logic gsel;
  logic win;
  logic inData;
  logic wHs;
  logic wLast;
  logic bHs;

  assign gsel   = gnt_q[1];
  assign inData = (state_q == ST_DATA);
  assign wHs    = inData & req_if.WVALID[gsel] & axi_if.M_AXI_WREADY;
  assign wLast  = inData & (cnt_q == len_q);
  assign bHs    = (state_q == ST_RESP) & axi_if.M_AXI_BVALID;

  // On a tie the requester that was not served last wins.
  always_comb begin
    win = 1'b0;
    case (req_if.REQ)
      2'b10:   win = 1'b1;
      2'b11:   win = ~last_q;
      default: win = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    resp_d  = resp_q;
    case (state_q)
      ST_IDLE: begin
        if (req_if.REQ != 2'b00) begin
          gnt_d   = win ? 2'b10 : 2'b01;
          addr_d  = win ? req_if.ADDR[63:32] : req_if.ADDR[31:0];
          len_d   = win ? req_if.LEN[15:8] : req_if.LEN[7:0];
          cnt_d   = 8'd0;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (axi_if.M_AXI_AWREADY) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (wHs) begin
          cnt_d = cnt_q + 8'd1;
          if (wLast) begin
            state_d = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        if (axi_if.M_AXI_BVALID) begin
          resp_d  = axi_if.M_AXI_BRESP;
          last_d  = gsel;
          gnt_d   = 2'b00;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // LAST resets to requester 1 so requester 0 takes the first tie.
  always_ff @(posedge CLK or posedge ARST) begin
    if (ARST) begin
      state_q <= ST_IDLE;
      gnt_q   <= 2'b00;
      addr_q  <= 32'd0;
      len_q   <= 8'd0;
      cnt_q   <= 8'd0;
      last_q  <= 1'b1;
      resp_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      resp_q  <= resp_d;
    end
  end

  assign axi_if.M_AXI_AWVALID = (state_q == ST_ADDR);
  assign axi_if.M_AXI_AWADDR  = addr_q;
  assign axi_if.M_AXI_AWLEN   = len_q;

  assign axi_if.M_AXI_WVALID  = inData & req_if.WVALID[gsel];
  assign axi_if.M_AXI_WLAST   = wLast;
  assign axi_if.M_AXI_WDATA   = inData ? (gsel ? req_if.WDATA[63:32] : req_if.WDATA[31:0]) : 32'd0;
  assign axi_if.M_AXI_WSTRB   = inData ? (gsel ? req_if.WSTRB[7:4] : req_if.WSTRB[3:0]) : 4'd0;
  assign axi_if.M_AXI_BREADY  = (state_q == ST_RESP);

  assign req_if.WREADY = inData ? (gsel ? {axi_if.M_AXI_WREADY, 1'b0}
                                        : {1'b0, axi_if.M_AXI_WREADY}) : 2'b00;
  assign req_if.GNT    = gnt_q;
  assign req_if.DONE   = bHs ? gnt_q : 2'b00;
  assign req_if.RESP   = resp_q;
  assign req_if.BUSY   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_draw_wrarb.sv
// Randomized self-checking bench for draw_wrarb against a burst-level model of
// round-robin arbitration, beat counting and response reporting.
module tb_draw_wrarb;

  logic clk;
  logic arst;

  draw_wrarb_req_if reqIf ();
  draw_wrarb_axi_if axiIf ();

  draw_wrarb dut (
    .CLK    (clk),
    .ARST   (arst),
    .req_if (reqIf),
    .axi_if (axiIf)
  );

  int checkCount = 0;
  int errorCount = 0;

  int         lastServed = 1;
  logic [1:0] respExp    = 2'b00;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pickWinner(input logic [1:0] req, input int last);
    if (req == 2'b01) return 0;
    if (req == 2'b10) return 1;
    return 1 - last;
  endfunction

  function automatic logic [1:0] oneHot(input int g);
    return (g == 1) ? 2'b10 : 2'b01;
  endfunction

  task automatic checkAllZero(input string where);
    checkOutput({where, "Gnt"},     reqIf.GNT, 0);
    checkOutput({where, "Done"},    reqIf.DONE, 0);
    checkOutput({where, "Resp"},    reqIf.RESP, 0);
    checkOutput({where, "Busy"},    reqIf.BUSY, 0);
    checkOutput({where, "WReady"},  reqIf.WREADY, 0);
    checkOutput({where, "AwValid"}, axiIf.M_AXI_AWVALID, 0);
    checkOutput({where, "AwAddr"},  axiIf.M_AXI_AWADDR, 0);
    checkOutput({where, "AwLen"},   axiIf.M_AXI_AWLEN, 0);
    checkOutput({where, "WValid"},  axiIf.M_AXI_WVALID, 0);
    checkOutput({where, "WLast"},   axiIf.M_AXI_WLAST, 0);
    checkOutput({where, "WData"},   axiIf.M_AXI_WDATA, 0);
    checkOutput({where, "BReady"},  axiIf.M_AXI_BREADY, 0);
  endtask

  // Entered and left on a falling edge with the arbiter idle.
  // mode 0: no stalls, 1: random stalls, 2: slave WREADY toggles 1-0-1-0.
  task automatic applyStimulus(input logic [1:0] reqPat, input logic [31:0] a0, input logic [31:0] a1,
                               input logic [7:0] l0, input logic [7:0] l1, input logic [1:0] bresp,
                               input int mode, input int abortBeat);
    int          g;
    logic [31:0] expAddr;
    logic [7:0]  expLen;
    int          beat;
    int          cyc;
    bit          done;
    bit          tog;

    reqIf.REQ  = reqPat;
    reqIf.ADDR = {a1, a0};
    reqIf.LEN  = {l1, l0};
    g       = pickWinner(reqPat, lastServed);
    expAddr = (g == 1) ? a1 : a0;
    expLen  = (g == 1) ? l1 : l0;
    @(negedge clk);

    // Post-grant changes to request inputs must not disturb the burst.
    if ($urandom_range(0, 1) == 1) reqIf.REQ = 2'b00;
    reqIf.ADDR = {$urandom, $urandom};
    reqIf.LEN  = 16'($urandom);

    done = 0;
    cyc  = 0;
    while (!done && cyc < 200) begin
      axiIf.M_AXI_AWREADY = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      checkOutput("gnt",     reqIf.GNT, oneHot(g));
      checkOutput("busy",    reqIf.BUSY, 1);
      checkOutput("awValid", axiIf.M_AXI_AWVALID, 1);
      checkOutput("awAddr",  axiIf.M_AXI_AWADDR, expAddr);
      checkOutput("awLen",   axiIf.M_AXI_AWLEN, expLen);
      checkOutput("wValidAddr", axiIf.M_AXI_WVALID, 0);
      checkOutput("wReadyAddr", reqIf.WREADY, 0);
      if (axiIf.M_AXI_AWREADY) done = 1;
      @(negedge clk);
      cyc++;
    end
    checkOutput("awHandshake", done, 1);
    axiIf.M_AXI_AWREADY = 1'b0;

    beat = 0;
    tog  = 1;
    cyc  = 0;
    while (beat <= int'(expLen) && cyc < 5000) begin
      if (beat == abortBeat) begin
        reqIf.WVALID       = 2'b00;
        axiIf.M_AXI_WREADY = 1'b0;
        reqIf.REQ          = 2'b00;
        arst               = 1'b1;
        #1;
        checkAllZero("abort");
        @(negedge clk);
        checkOutput("abortNoDone", reqIf.DONE, 0);
        arst       = 1'b0;
        lastServed = 1;
        respExp    = 2'b00;
        return;
      end
      reqIf.WVALID = (mode == 0) ? 2'b11 : 2'($urandom_range(0, 3));
      reqIf.WDATA  = {$urandom, $urandom};
      reqIf.WSTRB  = 8'($urandom);
      axiIf.M_AXI_WREADY = (mode == 0) ? 1'b1 : (mode == 2) ? tog : 1'($urandom_range(0, 1));
      tog = ~tog;
      #1;
      checkOutput("gntData",     reqIf.GNT, oneHot(g));
      checkOutput("wValid",      axiIf.M_AXI_WVALID, reqIf.WVALID[g]);
      checkOutput("wReadyG",     reqIf.WREADY[g], axiIf.M_AXI_WREADY);
      checkOutput("wReadyOther", reqIf.WREADY[1-g], 0);
      checkOutput("wLast",       axiIf.M_AXI_WLAST, (beat == int'(expLen)) ? 1 : 0);
      checkOutput("awValidData", axiIf.M_AXI_AWVALID, 0);
      checkOutput("bReadyData",  axiIf.M_AXI_BREADY, 0);
      checkOutput("respHeld",    reqIf.RESP, respExp);
      if (reqIf.WVALID[g]) begin
        checkOutput("wData", axiIf.M_AXI_WDATA, (g == 1) ? reqIf.WDATA[63:32] : reqIf.WDATA[31:0]);
        checkOutput("wStrb", axiIf.M_AXI_WSTRB, (g == 1) ? reqIf.WSTRB[7:4] : reqIf.WSTRB[3:0]);
        if (axiIf.M_AXI_WREADY) beat++;
      end
      @(negedge clk);
      cyc++;
    end
    checkOutput("allBeats", beat, int'(expLen) + 1);
    reqIf.WVALID       = 2'b00;
    axiIf.M_AXI_WREADY = 1'b0;

    done = 0;
    cyc  = 0;
    while (!done && cyc < 200) begin
      axiIf.M_AXI_BVALID = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      axiIf.M_AXI_BRESP  = bresp;
      #1;
      checkOutput("bReady",    axiIf.M_AXI_BREADY, 1);
      checkOutput("wValidRsp", axiIf.M_AXI_WVALID, 0);
      checkOutput("gntRsp",    reqIf.GNT, oneHot(g));
      checkOutput("done",      reqIf.DONE, axiIf.M_AXI_BVALID ? oneHot(g) : 2'b00);
      checkOutput("respPrev",  reqIf.RESP, respExp);
      if (axiIf.M_AXI_BVALID) done = 1;
      @(negedge clk);
      cyc++;
    end
    checkOutput("bHandshake", done, 1);
    axiIf.M_AXI_BVALID = 1'b0;
    reqIf.REQ          = 2'b00;
    lastServed = g;
    respExp    = bresp;
    #1;
    checkOutput("doneCleared", reqIf.DONE, 0);
    checkOutput("gntCleared",  reqIf.GNT, 0);
    checkOutput("busyCleared", reqIf.BUSY, 0);
    checkOutput("respNew",     reqIf.RESP, respExp);
    checkOutput("bReadyIdle",  axiIf.M_AXI_BREADY, 0);
  endtask

  initial begin
    arst                = 1'b1;
    reqIf.REQ           = 2'b00;
    reqIf.ADDR          = 64'd0;
    reqIf.LEN           = 16'd0;
    reqIf.WDATA         = 64'd0;
    reqIf.WSTRB         = 8'd0;
    reqIf.WVALID        = 2'b00;
    axiIf.M_AXI_AWREADY = 1'b0;
    axiIf.M_AXI_WREADY  = 1'b0;
    axiIf.M_AXI_BRESP   = 2'b00;
    axiIf.M_AXI_BVALID  = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkAllZero("reset");
    @(negedge clk);
    arst = 1'b0;

    applyStimulus(2'b01, 32'h1000_0000, 32'h2000_0000, 8'd3, 8'd5, 2'b00, 0, -1);

    // Tie arbitration and alternation under a held double request.
    applyStimulus(2'b11, 32'h1000_0100, 32'h2000_0100, 8'd2, 8'd1, 2'b00, 1, -1);
    applyStimulus(2'b11, 32'h1000_0200, 32'h2000_0200, 8'd1, 8'd2, 2'b01, 1, -1);
    applyStimulus(2'b11, 32'h1000_0300, 32'h2000_0300, 8'd0, 8'd0, 2'b00, 0, -1);

    applyStimulus(2'b01, 32'h1000_0400, 32'h2000_0400, 8'd7, 8'd3, 2'b00, 2, -1);
    applyStimulus(2'b10, 32'h1000_0500, 32'h2000_0500, 8'd0, 8'd0, 2'b00, 1, -1);
    applyStimulus(2'b10, 32'h1000_0600, 32'h2000_0600, 8'd9, 8'd255, 2'b00, 1, -1);

    applyStimulus(2'b10, 32'h1000_0700, 32'h2000_0700, 8'd1, 8'd2, 2'b10, 1, -1);
    applyStimulus(2'b01, 32'h1000_0800, 32'h2000_0800, 8'd2, 8'd1, 2'b11, 1, -1);

    applyStimulus(2'b01, 32'h1000_0900, 32'h2000_0900, 8'd7, 8'd7, 2'b00, 0, 2);
    applyStimulus(2'b10, 32'h1000_0a00, 32'h2000_0a40, 8'd1, 8'd3, 2'b00, 1, -1);
    applyStimulus(2'b11, 32'h1000_0b00, 32'h2000_0b00, 8'd1, 8'd1, 2'b00, 0, -1);

    for (int i = 0; i < 30; i++) begin
      applyStimulus(2'($urandom_range(1, 3)), $urandom & 32'hffff_fffc, $urandom & 32'hffff_fffc,
                    8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)),
                    2'($urandom_range(0, 3)), $urandom_range(0, 2), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
